// File: rtl/result_encoder_pkg.sv
// result_encoder_pkg: shared types, defaults and symbol codes for the class result path
package result_encoder_pkg;
   localparam int NUM_CLASS_DEF = 16;
   localparam int IDXW_DEF      = 5;
   localparam int NONE_CODE_DEF = 31;
   typedef enum logic [1:0] {IDLE, COLLECT, DECODE, HOLD} state_t;
   localparam int SYM_PLUS   = 10;
   localparam int SYM_MINUS  = 11;
   localparam int SYM_MUL    = 12;
   localparam int SYM_DIV    = 13;
   localparam int SYM_LPAREN = 14;
   localparam int SYM_RPAREN = 15;
endpackage

// File: rtl/result_encoder_onehot_encoder.sv
// onehot_encoder: lowest-set index plus none/multiple flags for a class vector
module onehot_encoder #(
   parameter int N    = 16,
   parameter int W    = 5,
   parameter int NONE = 31
) (
   input  logic [N-1:0] vec,
   output logic [W-1:0] idx,
   output logic         no_hit,
   output logic         multi_hit
);
   always_comb begin
      idx = W'(NONE);
      for (int i = N - 1; i >= 0; i--)
         if (vec[i]) idx = W'(i);
   end
   assign no_hit    = (vec == '0);
   assign multi_hit = |(vec & (vec - N'(1)));
endmodule

// File: rtl/result_encoder.sv
// result_encoder: collects serial neuron decisions, encodes the winning class, hands it off on valid/ready
module result_encoder
   import result_encoder_pkg::*;
#(
   parameter int NUM_CLASS = NUM_CLASS_DEF,
   parameter int IDXW      = IDXW_DEF,
   parameter int NONE_CODE = NONE_CODE_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 bit_in,
   input  logic                 bit_valid,
   output logic                 bit_ready,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [IDXW-1:0]      class_idx,
   output logic [NUM_CLASS-1:0] class_vec,
   output logic                 multi_hit,
   output logic                 no_hit,
   output logic                 busy
);
   localparam int CW = $clog2(NUM_CLASS);
   state_t          state;
   logic [CW-1:0]   cnt;
   logic [IDXW-1:0] enc_idx;
   logic            enc_none;
   logic            enc_multi;
   onehot_encoder #(.N(NUM_CLASS), .W(IDXW), .NONE(NONE_CODE)) u_enc (
      .vec       (class_vec),
      .idx       (enc_idx),
      .no_hit    (enc_none),
      .multi_hit (enc_multi)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         class_vec <= '0;
         class_idx <= '0;
         multi_hit <= 1'b0;
         no_hit    <= 1'b0;
         res_valid <= 1'b0;
         bit_ready <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= COLLECT;
               class_vec <= '0;
               cnt       <= '0;
               bit_ready <= 1'b1;
               busy      <= 1'b1;
            end
            COLLECT: if (start) begin
               class_vec <= '0;
               cnt       <= '0;
            end else if (bit_valid) begin
               class_vec[cnt] <= bit_in;
               cnt            <= cnt + 1'b1;
               if (cnt == CW'(NUM_CLASS - 1)) begin
                  state     <= DECODE;
                  bit_ready <= 1'b0;
               end
            end
            DECODE: begin
               class_idx <= enc_idx;
               no_hit    <= enc_none;
               multi_hit <= enc_multi;
               res_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: if (res_ready) begin
               res_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_result_encoder.sv
// tb_result_encoder: table-driven and randomized checks of result_encoder against a list-based model
module tb_result_encoder;
   logic        clk = 0;
   logic        reset_n = 0;
   logic        start = 0;
   logic        bit_in = 0;
   logic        bit_valid = 0;
   logic        res_ready = 0;
   logic        bit_ready;
   logic        res_valid;
   logic [4:0]  class_idx;
   logic [15:0] class_vec;
   logic        multi_hit;
   logic        no_hit;
   logic        busy;
   int total = 0;
   int bad = 0;

   result_encoder dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .class_idx (class_idx),
      .class_vec (class_vec),
      .multi_hit (multi_hit),
      .no_hit    (no_hit),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] vec;
      int          idx;
      bit          multi;
      bit          none;
      int          hold;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference: list the fired neurons, then read the answer off the list
   function automatic void model(input logic [15:0] v, output int idx, output bit m, output bit n);
      int q[$];
      for (int i = 0; i < 16; i++) if (v[i]) q.push_back(i);
      n = (q.size() == 0);
      m = (q.size() > 1);
      idx = n ? 31 : q[0];
   endfunction

   task automatic send_bits(input logic [15:0] v, input bit gaps);
      for (int i = 0; i < 16; i++) begin
         if (gaps) begin
            int g = $urandom_range(0, 3);
            for (int k = 0; k < g; k++) begin
               bit_valid = 0; bit_in = 1'($urandom); step();
            end
         end
         bit_valid = 1; bit_in = v[i]; step();
      end
      bit_valid = 0;
   endtask

   task automatic finish(input logic [15:0] v, input int idx, input bit m, input bit n,
                         input int hold, input bit noisy);
      chk("decode_rv", res_valid, 0);
      chk("decode_br", bit_ready, 0);
      res_ready = (hold == 0);
      if (noisy) begin start = 1; bit_valid = 1; bit_in = 1; end
      step();
      chk("rv_high", res_valid, 1);
      chk("idx", class_idx, idx);
      chk("vec", class_vec, v);
      chk("multi", multi_hit, m);
      chk("none", no_hit, n);
      for (int w = 1; w < hold; w++) begin
         if (noisy) begin start = 1'($urandom); bit_valid = 1'($urandom); bit_in = 1'($urandom); end
         step();
         chk("hold_rv", res_valid, 1);
         chk("hold_idx", class_idx, idx);
         chk("hold_vec", class_vec, v);
      end
      res_ready = 1;
      step();
      start = 0; bit_valid = 0;
      chk("done_rv", res_valid, 0);
      chk("done_busy", busy, 0);
      chk("keep_idx", class_idx, idx);
      res_ready = 0;
   endtask

   task automatic frame(input logic [15:0] v, input int idx, input bit m, input bit n,
                        input int hold, input bit gaps, input bit noisy);
      start = 1; step(); start = 0;
      chk("start_busy", busy, 1);
      chk("start_br", bit_ready, 1);
      send_bits(v, gaps);
      finish(v, idx, m, n, hold, noisy);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_idx"}, class_idx, 0);
      chk({tag, "_vec"}, class_vec, 0);
      chk({tag, "_rv"}, res_valid, 0);
      chk({tag, "_br"}, bit_ready, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_multi"}, multi_hit, 0);
      chk({tag, "_none"}, no_hit, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[8];
      tbl[0] = '{16'h0080, 7, 0, 0, 0};
      tbl[1] = '{16'h1008, 3, 1, 0, 0};
      tbl[2] = '{16'h0000, 31, 0, 1, 0};
      tbl[3] = '{16'h0400, 10, 0, 0, 5};
      tbl[4] = '{16'h8000, 15, 0, 0, 2};
      tbl[5] = '{16'hFFFF, 0, 1, 0, 0};
      tbl[6] = '{16'h0001, 0, 0, 0, 1};
      tbl[7] = '{16'hA000, 13, 1, 0, 3};
      step(); step();
      chk_zero("rst");
      reset_n = 1;
      step();
      chk_zero("idle");
      for (int t = 0; t < 8; t++)
         frame(tbl[t].vec, tbl[t].idx, tbl[t].multi, tbl[t].none, tbl[t].hold, 0, 0);
      // abort mid-frame; the bit offered alongside the second start must be dropped
      start = 1; step(); start = 0;
      for (int i = 0; i < 6; i++) begin bit_valid = 1; bit_in = 1; step(); end
      start = 1; bit_valid = 1; bit_in = 1; step();
      start = 0; bit_valid = 0;
      chk("abort_busy", busy, 1);
      chk("abort_br", bit_ready, 1);
      chk("abort_vec", class_vec, 0);
      send_bits(16'h8000, 0);
      finish(16'h8000, 15, 0, 0, 0, 0);
      // reset mid-frame, checked before any further clock edge
      start = 1; step(); start = 0;
      for (int i = 0; i < 9; i++) begin bit_valid = 1; bit_in = 1; step(); end
      bit_valid = 0;
      #2 reset_n = 0;
      #1 chk_zero("async");
      #1 reset_n = 1;
      for (int i = 0; i < 3; i++) begin
         bit_valid = 1; bit_in = 1; step();
         chk("idle_br", bit_ready, 0);
         chk("idle_busy", busy, 0);
         chk("idle_vec", class_vec, 0);
      end
      bit_valid = 0;
      for (int r = 0; r < 25; r++) begin
         logic [15:0] v;
         int idx;
         bit m, n;
         v = 16'($urandom);
         if (r % 5 == 0) v = 16'(1) << $urandom_range(0, 15);
         if (r == 7) v = 16'h0000;
         model(v, idx, m, n);
         frame(v, idx, m, n, $urandom_range(0, 4), 1, 1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
